// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-fetch engine with a DEPTH-entry {pc, inst} queue toward decode
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       imem_req_o,
    output logic [XLEN-1:0]            imem_addr_o,
    input  logic [31:0]                imem_data_i,
    input  logic                       redirect_i,
    input  logic [XLEN-1:0]            redirect_addr_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [31:0]                inst_o,
    output logic [XLEN-1:0]            pc_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] issued_pc;
    logic            inflight;
    logic            kill;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     level;

    assign valid_o = (count != '0);
    assign pop     = valid_o & ready_i;
    // Slots already committed: queued entries plus the response still on its way.
    assign level   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign issue   = !rst_i && !redirect_i && (level < (CW+1)'(DEPTH));
    assign push    = inflight && !kill && !redirect_i && !rst_i;

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc;
    assign inst_o      = valid_o ? inst_mem[rd_ptr] : NOP;
    assign pc_o        = valid_o ? pc_mem[rd_ptr] : '0;
    assign count_o     = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            inflight  <= 1'b0;
            kill      <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_addr_i & ~XLEN'(3);
            inflight <= 1'b0;
            kill     <= inflight;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            kill     <= 1'b0;
            if (issue) begin
                fetch_pc  <= fetch_pc + XLEN'(4);
                issued_pc <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr]   <= issued_pc;
            inst_mem[wr_ptr] <= imem_data_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    fetch_queue dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr),
        .valid_o(valid), .ready_i(ready), .inst_o(inst), .pc_o(pc), .count_o(count)
    );

    always #5 clk = ~clk;

    // ROM model: each word holds its own address, returned one cycle after the address.
    always @(posedge clk) imem_data <= imem_addr;

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    // Leaves the bench at the start of c0 (first cycle with rst=0).
    task automatic do_reset;
        rst = 1'b1; redirect = 1'b0; ready = 1'b0; redirect_addr = '0;
        next; next;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; redirect = 1'b0; ready = 1'b0; redirect_addr = '0;
        next; next;
        settle;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %h want 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h want 0", valid); end
        checks++; if (inst !== 32'h13) begin errors++; $display("FAIL reset_inst got %h want 00000013", inst); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    endtask

    task automatic test_stream;
        do_reset;
        ready = 1'b1;
        settle;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_c0_req got req=%h addr=%h want 1/0", imem_req, imem_addr); end
        next; settle;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got %h want 0", valid); end
        next;
        for (int k = 0; k < 6; k++) begin
            settle;
            checks++;
            if (valid !== 1'b1 || pc !== 32'(4*k) || inst !== 32'(4*k)) begin
                errors++; $display("FAIL stream_k%0d got v=%h pc=%h inst=%h want 1/%h/%h", k, valid, pc, inst, 32'(4*k), 32'(4*k));
            end
            next;
        end
    endtask

    task automatic test_full;
        do_reset;
        for (int c = 0; c < 5; c++) next;
        settle;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %h want 0", imem_req); end
        next; settle;
        checks++; if (count !== 3'd4 || imem_req !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL full_hold got cnt=%0d req=%h pc=%h want 4/0/0", count, imem_req, pc); end
        next;
        ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL full_reissue got req=%h addr=%h want 1/10", imem_req, imem_addr); end
        for (int k = 0; k < 6; k++) begin
            settle;
            checks++;
            if (valid !== 1'b1 || pc !== 32'(4*k)) begin
                errors++; $display("FAIL full_drain_k%0d got v=%h pc=%h want 1/%h", k, valid, pc, 32'(4*k));
            end
            next;
        end
    endtask

    task automatic test_redirect(input logic [31:0] target, input logic [31:0] aligned);
        do_reset;
        ready = 1'b1;
        next; next; next;
        redirect = 1'b1; redirect_addr = target;
        settle;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_t got %h want 0", imem_req); end
        next;
        redirect = 1'b0;
        settle;
        checks++; if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== aligned) begin errors++; $display("FAIL redir_t1 got v=%h req=%h addr=%h want 0/1/%h", valid, imem_req, imem_addr, aligned); end
        next; settle;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL redir_t2_valid got %h want 0", valid); end
        next; settle;
        checks++; if (valid !== 1'b1 || pc !== aligned || inst !== aligned) begin errors++; $display("FAIL redir_t3 got v=%h pc=%h inst=%h want 1/%h/%h", valid, pc, inst, aligned, aligned); end
        next; settle;
        checks++; if (valid !== 1'b1 || pc !== aligned + 32'h4) begin errors++; $display("FAIL redir_t4 got v=%h pc=%h want 1/%h", valid, pc, aligned + 32'h4); end
        next;
    endtask

    task automatic test_redirect_pop;
        do_reset;
        next; next; next; next;
        redirect = 1'b1; redirect_addr = 32'h200; ready = 1'b1;
        settle;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rpop_pre_count got %0d want 3", count); end
        next;
        redirect = 1'b0;
        settle;
        checks++; if (count !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL rpop_flush got cnt=%0d v=%h want 0/0", count, valid); end
        next; settle;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rpop_t2_valid got %h want 0", valid); end
        next; settle;
        checks++; if (valid !== 1'b1 || pc !== 32'h200) begin errors++; $display("FAIL rpop_target got v=%h pc=%h want 1/200", valid, pc); end
        next;
    endtask

    task automatic test_reset_pulse;
        do_reset;
        next; next; next; next;
        rst = 1'b1;
        settle;
        checks++; if (count !== 3'd3 || imem_req !== 1'b0) begin errors++; $display("FAIL rpulse_pre got cnt=%0d req=%h want 3/0", count, imem_req); end
        next;
        rst = 1'b0; ready = 1'b1;
        settle;
        checks++; if (valid !== 1'b0 || count !== 3'd0 || pc !== 32'h0 || inst !== 32'h13) begin errors++; $display("FAIL rpulse_outs got v=%h cnt=%0d pc=%h inst=%h want 0/0/0/13", valid, count, pc, inst); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rpulse_restart got req=%h addr=%h want 1/0", imem_req, imem_addr); end
        next; settle;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rpulse_c1_valid got %h want 0", valid); end
        next; settle;
        checks++; if (valid !== 1'b1 || pc !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL rpulse_first got v=%h pc=%h inst=%h want 1/0/0", valid, pc, inst); end
        next; settle;
        checks++; if (valid !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL rpulse_second got v=%h pc=%h want 1/4", valid, pc); end
        next;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_full;
        test_redirect(32'h100, 32'h100);
        test_redirect(32'h103, 32'h100);
        test_redirect_pop;
        test_reset_pulse;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the bare PC / PC+4 adder / PC-select mux with a fetch engine that owns the PC and issues requests to the synchronous instruction ROM. Fetched instructions are buffered in a DEPTH-entry queue, and the head is presented to decode over a valid/ready handshake. Branch and jump redirects flush the queue and discard any in-flight fetch, so decode can stall without losing instructions.

## Interface
- XLEN, 32: address/PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: first fetch address after reset; bits [1:0] must be 0.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- imem_req_o  out  1  fetch request this cycle.
- imem_addr_o  out  XLEN  fetch address; equals the internal fetch PC.
- imem_data_i  in  32  ROM data; valid exactly one cycle after a request.
- redirect_i  in  1  flush and restart the fetch stream.
- redirect_addr_i  in  XLEN  new fetch target; bits [1:0] ignored and forced to 0.
- valid_o  out  1  queue head holds an instruction.
- ready_i  in  1  decode accepts the head.
- inst_o  out  32  head instruction; 32'h00000013 (NOP) when empty.
- pc_o  out  XLEN  head PC; 0 when empty.
- count_o  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- State:
  - fetch PC register.
  - inflight flag: a request was issued last cycle.
  - kill flag: the in-flight response is stale.
  - circular queue of {pc, inst} with read/write pointers and a count.
- Pop: `valid_o & ready_i` removes the head at the clock edge.
- Issue condition: `count + inflight - pop < DEPTH`, with `!redirect_i`, and `!rst_i`.
  - On issue, `imem_req_o=1`. At the edge, inflight←1 and the fetch PC←PC+4.
  - Addition wraps modulo 2^XLEN.
- Response: in the cycle after an issue, if kill=0, `{issued PC, imem_data_i}` is pushed at the edge. If kill=1, the data is dropped.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - The issue rule guarantees there is no push into a full queue.
- Redirect (cycle t):
  - No request is issued in cycle t.
  - At the edge, the queue is emptied: pointers and count go to 0.
  - The fetch PC←{redirect_addr_i[XLEN-1:2],2'b00}.
  - kill←inflight, so a response due in t+1 is dropped. Any response arriving in cycle t is also dropped.
- Redirect has priority over pop and push. A handshake that completes in cycle t still counts as accepted by decode, but the queue is flushed regardless.
- Back-to-back redirects: the last one wins.
- Reset:
  - Fetch PC←RESET_PC; queue empty; inflight=0; kill=0.
  - All outputs take their empty/idle values in the cycle after rst_i is sampled high.
  - imem_req_o=0 while rst_i=1.
  - Reset mid-operation discards queue contents and any in-flight response.

## Timing
- Reset values: `imem_req_o=0`, `imem_addr_o=RESET_PC`, `valid_o=0`, `inst_o=32'h00000013`, `pc_o=0`, `count_o=0`.
- First rst_i=0 cycle is c0:
  - c0: req at RESET_PC.
  - c1: data arrives; push at the c1 edge.
  - c2: `valid_o=1`.
- Fetch-to-decode latency: 2 cycles. Steady-state throughput is 1 instruction/cycle while ready_i=1.
- Redirect at t:
  - t+1: req at the target.
  - t+3: `valid_o=1` with `pc_o=target`.
  - valid_o=0 in t+1 and t+2.
- Full queue with ready_i=0: requests stop once `count+inflight=DEPTH`. A pop in cycle c re-enables issue in the same cycle c.
- Outputs inst_o, pc_o, valid_o and count_o are driven from registers/storage only. They have no combinational path from ready_i or redirect_i.

## Test plan
- Reset, then ready_i=1 with ROM word = address: valid_o rises in c2; pc_o/inst_o show 0x0, 0x4, 0x8, … on consecutive cycles with no bubbles.
- ready_i=0 from c2 with DEPTH=4: count_o reaches 4, imem_req_o holds 0, and PCs 0x0–0xC are retained. Release ready_i: 0x0, 0x4, 0x8, 0xC, 0x10 follow in order, with no gap after the first pop.
- redirect_i with target 0x100 asserted in the cycle after a request to 0x8: the 0x8 data is dropped, valid_o=0 for 2 cycles, then pc_o=0x100, 0x104.
- Misaligned redirect to 0x103: first valid pc_o=0x100.
- redirect_i and ready_i both high with count_o=3: count_o=0 next cycle; the next valid pc_o equals the target.
- rst_i pulsed for 1 cycle with 3 entries queued and one in flight: all outputs return to reset values; fetch restarts at RESET_PC; no stale entry appears.
